count24h: RTL and testbench
===========================

COUNT24H -- requirements
Module: count24h

Interface
REQ-001 SHALL have ports: clk_i  input  1  system clock; the only clock in the block.
REQ-002 SHALL have port: rst_i  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: clk60m_i  input  1  hour-rate level from the minutes stage; asynchronous to clk_i; one rising edge per hour.
REQ-004 SHALL have port: inc_i  input  1  user hour-adjust button; asynchronous, pre-debounced level.
REQ-005 SHALL have port: ival_i  input  5  initial hour (binary), loaded on reset.
REQ-006 SHALL have port: hour_tens_o  output  4  BCD tens digit of the displayed hour, for the 7-segment driver.
REQ-007 SHALL have port: hour_units_o  output  4  BCD units digit of the displayed hour.
REQ-008 SHALL have port: pm_o  output  1  PM indicator.
REQ-009 SHALL have port: day_o  output  1  one-cycle day-carry pulse.

Function
REQ-010 SHALL pass clk60m_i and inc_i each through a two-flop synchronizer followed by one history flop.
REQ-011 SHALL detect an hour event as synchronized clk60m high with history low, and an adjust event the same way on inc_i.
REQ-012 SHALL keep a 5-bit binary hour register, range 0..23.
REQ-013 SHALL on any event increment the hour register, with 23 -> 0 wrap.
REQ-014 SHALL, when an hour event and an adjust event coincide in one cycle, advance by exactly one hour.
REQ-015 SHALL pulse day_o high for exactly one clk_i cycle when an hour event (alone or coincident) wraps 23 -> 0.
REQ-016 SHALL NOT assert day_o on a wrap caused only by an adjust event.
REQ-017 SHALL update the hour register on the 3rd rising clk_i edge after a clk60m_i or inc_i rise that meets setup (2 sync + 1 edge-detect).
REQ-018 SHALL register the BCD outputs and pm_o one cycle after the hour register, giving 4 cycles total input-to-output latency.
REQ-019 SHALL keep the BCD outputs within 0..2 (tens) and 0..9 (units); codes 10..15 never appear.
REQ-020 SHALL ignore levels held on clk60m_i or inc_i; only rising edges count, so a held button gives one increment.

Reset
REQ-021 SHALL on rst_i load the hour register with ival_i when ival_i <= 23, and with 0 otherwise.
REQ-022 SHALL on rst_i reset the clk60m synchronizer and history flops to 1, so no spurious hour event follows reset (the minutes stage resets its output high).
REQ-023 SHALL on rst_i reset the inc synchronizer and history flops to 0.
REQ-024 SHALL on rst_i clear day_o to 0 and load the output registers from the reset hour value, so outputs are valid on the cycle after reset.
REQ-025 SHALL discard events pending in the pipeline when rst_i asserts mid-operation; rst_i has priority over all events.

Configuration
REQ-026 SHALL support the macro COUNT24H_12H_EN.
REQ-027 SHALL, without the macro, display the hour register directly as 00..23 in BCD and tie pm_o to 0.
REQ-028 SHALL, with the macro, display 12-hour format: hour 0 -> 12 with pm_o=0; 1..11 -> 1..11 with pm_o=0; 12 -> 12 with pm_o=1; 13..23 -> 1..11 with pm_o=1.
REQ-029 SHALL, with or without the macro, keep the internal 0..23 count and the day_o behaviour unchanged.

Verification
REQ-030 SHALL cover: rst_i with ival_i=7, then one clk60m_i rise -> tens=0, units=8, 4 cycles after the rise; day_o stays 0.
REQ-031 SHALL cover: ival_i=23, clk60m_i rise -> tens=0, units=0, and day_o high for exactly 1 cycle.
REQ-032 SHALL cover: ival_i=23, inc_i rise only -> tens=0, units=0, and day_o stays 0.
REQ-033 SHALL cover: ival_i=9, clk60m_i and inc_i rising in the same clk_i cycle -> tens=1, units=0 (single increment).
REQ-034 SHALL cover: ival_i=30, release reset with clk60m_i held at 1 -> tens=0, units=0; no increment occurs.
REQ-035 SHALL cover, with COUNT24H_12H_EN: ival_i=12 -> 12/pm=1; one hour event -> 01/pm=1; ival_i=0 -> 12/pm=0.

Source files
------------

// File: rtl/count24h.sv
// count24h -- 24-hour hour counter with BCD display outputs.
//
// Counts hours 0..23 from two asynchronous sources: the hour-rate level from
// the minutes stage (clk60m_i) and a pre-debounced user adjust button (inc_i).
// Each source is synchronized into the clk_i domain and rising-edge detected.
// Any event advances the hour by one; coincident events still advance by one.
// day_o pulses for one cycle only when a real hour event wraps 23 -> 0.
//
// Optional feature: define COUNT24H_12H_EN to show the hour in 12-hour
// format with a PM indicator. The internal 0..23 count and day_o are the
// same in both builds.
//
// Latency: an input rise that meets setup updates the hour register on the
// 3rd rising clk_i edge and the display registers on the 4th.

module count24h (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk60m_i,
    input  logic       inc_i,
    input  logic [4:0] ival_i,
    output logic [3:0] hour_tens_o,
    output logic [3:0] hour_units_o,
    output logic       pm_o,
    output logic       day_o
);

    localparam logic [4:0] LAST_HOUR = 5'd23;

    // Display fields packed together so one function can produce all of them.
    typedef struct packed {
        logic       pm;
        logic [3:0] tens;
        logic [3:0] units;
    } disp_t;

    // Maps a 0..23 hour onto the digits shown on the 7-segment driver.
    function automatic disp_t to_display(input logic [4:0] hour);
        disp_t      d;
        logic [4:0] shown;
`ifdef COUNT24H_12H_EN
        d.pm = (hour >= 5'd12);
        if (hour == 5'd0) begin
            shown = 5'd12;
        end else if (hour > 5'd12) begin
            shown = hour - 5'd12;
        end else begin
            shown = hour;
        end
`else
        d.pm  = 1'b0;
        shown = hour;
`endif
        if (shown >= 5'd20) begin
            d.tens  = 4'd2;
            d.units = 4'(shown - 5'd20);
        end else if (shown >= 5'd10) begin
            d.tens  = 4'd1;
            d.units = 4'(shown - 5'd10);
        end else begin
            d.tens  = 4'd0;
            d.units = 4'(shown);
        end
        return d;
    endfunction

    // Two synchronizer flops plus one history flop per asynchronous input.
    logic [1:0] c60_sync;
    logic       c60_hist;
    logic [1:0] inc_sync;
    logic       inc_hist;

    logic       hour_evt;
    logic       adj_evt;
    logic [4:0] hour_q;
    logic [4:0] hour_next;
    logic       day_next;
    logic [4:0] rst_hour;
    disp_t      disp_next;
    disp_t      disp_rst;

    // Out-of-range initial values fall back to midnight.
    assign rst_hour = (ival_i <= LAST_HOUR) ? ival_i : 5'd0;
    assign disp_rst = to_display(rst_hour);
    assign disp_next = to_display(hour_q);

    // Synchronize both inputs and keep one cycle of history for edge detect.
    // clk60m resets high because the minutes stage resets its output high, so
    // its first post-reset sample is not mistaken for a rising edge.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour; blocking here would
        // collapse the synchronizer chain into a single stage.
        if (rst_i) begin
            c60_sync <= 2'b11;
            c60_hist <= 1'b1;
            inc_sync <= 2'b00;
            inc_hist <= 1'b0;
        end else begin
            c60_sync <= {c60_sync[0], clk60m_i};
            c60_hist <= c60_sync[1];
            inc_sync <= {inc_sync[0], inc_i};
            inc_hist <= inc_sync[1];
        end
    end

    assign hour_evt = c60_sync[1] & ~c60_hist;
    assign adj_evt  = inc_sync[1] & ~inc_hist;

    // Next hour and day carry; coincident events still count as one step.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        hour_next = hour_q;
        day_next  = 1'b0;
        if (hour_evt || adj_evt) begin
            if (hour_q == LAST_HOUR) begin
                hour_next = 5'd0;
                day_next  = hour_evt;
            end else begin
                hour_next = hour_q + 5'd1;
            end
        end
    end

    // Hour register and day pulse; reset wins over any pending event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hour_q <= rst_hour;
            day_o  <= 1'b0;
        end else begin
            hour_q <= hour_next;
            day_o  <= day_next;
        end
    end

    // Display registers trail the hour register by one cycle; on reset they
    // load straight from the reset hour so they are valid right after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hour_tens_o  <= disp_rst.tens;
            hour_units_o <= disp_rst.units;
            pm_o         <= disp_rst.pm;
        end else begin
            hour_tens_o  <= disp_next.tens;
            hour_units_o <= disp_next.units;
            pm_o         <= disp_next.pm;
        end
    end

endmodule

// File: tb/tb_count24h.sv
// tb_count24h -- self-checking bench for count24h.
//
// A behavioural model keeps the hour as a plain integer and derives the
// expected display with division/modulo. Inputs change on the falling edge;
// outputs are sampled on the falling edge after each rising edge.

`timescale 1ns/1ps

module tb_count24h;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       clk60m_i = 1'b0;
    logic       inc_i = 1'b0;
    logic [4:0] ival_i = 5'd0;
    logic [3:0] hour_tens_o;
    logic [3:0] hour_units_o;
    logic       pm_o;
    logic       day_o;

    int n_tests = 0;
    int n_fail  = 0;
    int model_h = 0;

    count24h dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clk60m_i     (clk60m_i),
        .inc_i        (inc_i),
        .ival_i       (ival_i),
        .hour_tens_o  (hour_tens_o),
        .hour_units_o (hour_units_o),
        .pm_o         (pm_o),
        .day_o        (day_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected digits for a 0..23 hour.
    function automatic int exp_tens(input int h);
        int shown;
`ifdef COUNT24H_12H_EN
        shown = (h % 12 == 0) ? 12 : h % 12;
`else
        shown = h;
`endif
        return shown / 10;
    endfunction

    function automatic int exp_units(input int h);
        int shown;
`ifdef COUNT24H_12H_EN
        shown = (h % 12 == 0) ? 12 : h % 12;
`else
        shown = h;
`endif
        return shown % 10;
    endfunction

    function automatic int exp_pm(input int h);
`ifdef COUNT24H_12H_EN
        return (h >= 12) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check_disp(input string tag, input int h);
        check({tag, ".tens"},  32'(hour_tens_o),  32'(exp_tens(h)));
        check({tag, ".units"}, 32'(hour_units_o), 32'(exp_units(h)));
        check({tag, ".pm"},    32'(pm_o),         32'(exp_pm(h)));
    endtask

    // Reset with a given initial hour and clk60m level; checks the display
    // right after reset and that no increment follows release.
    task automatic do_reset(input logic [4:0] iv, input logic c60);
        int day_cnt = 0;
        @(negedge clk_i);
        rst_i    = 1'b1;
        ival_i   = iv;
        clk60m_i = c60;
        inc_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        model_h = (int'(iv) <= 23) ? int'(iv) : 0;
        check_disp("reset", model_h);
        check("reset.day", 32'(day_o), 32'd0);
        rst_i = 1'b0;
        repeat (5) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (day_o) day_cnt++;
        end
        check_disp("post_reset", model_h);
        check("post_reset.day", 32'(day_cnt), 32'd0);
    endtask

    // One hour and/or adjust rise held for 'hold' cycles; checks the latency
    // boundary, the single increment, and the day pulse count.
    task automatic run_event(input bit h_ev, input bit a_ev, input int hold);
        int  old_h;
        int  day_cnt = 0;
        int  exp_day;
        if (clk60m_i || inc_i) begin
            @(negedge clk_i);
            clk60m_i = 1'b0;
            inc_i    = 1'b0;
            repeat (4) @(negedge clk_i);
        end
        old_h   = model_h;
        model_h = (model_h + 1) % 24;
        exp_day = (h_ev && old_h == 23) ? 1 : 0;
        @(negedge clk_i);
        if (h_ev) clk60m_i = 1'b1;
        if (a_ev) inc_i    = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (day_o) day_cnt++;
            if (e == 3) check_disp("lat3_old", old_h);
            if (e == 4) check_disp("lat4_new", model_h);
            if (e == hold) begin
                clk60m_i = 1'b0;
                inc_i    = 1'b0;
            end
        end
        repeat (4) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (day_o) day_cnt++;
        end
        check_disp("held", model_h);
        check("day_pulses", 32'(day_cnt), 32'(exp_day));
    endtask

    // Reset arriving while an event is still in the synchronizers.
    task automatic mid_reset(input int delay, input logic [4:0] iv);
        @(negedge clk_i);
        clk60m_i = 1'b1;
        inc_i    = 1'b1;
        repeat (delay) @(negedge clk_i);
        rst_i  = 1'b1;
        inc_i  = 1'b0;
        ival_i = iv;
        repeat (2) @(negedge clk_i);
        rst_i   = 1'b0;
        model_h = (int'(iv) <= 23) ? int'(iv) : 0;
        repeat (6) @(negedge clk_i);
        check_disp("mid_reset", model_h);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Directed cases.
        do_reset(5'd7, 1'b0);
        run_event(1'b1, 1'b0, 5);
        check("hour7_to_8.units", 32'(hour_units_o), 32'(exp_units(8)));

        do_reset(5'd23, 1'b0);
        run_event(1'b1, 1'b0, 5);

        do_reset(5'd23, 1'b0);
        run_event(1'b0, 1'b1, 6);

        do_reset(5'd9, 1'b0);
        run_event(1'b1, 1'b1, 5);

        do_reset(5'd30, 1'b1);
        run_event(1'b0, 1'b1, 8);

        do_reset(5'd12, 1'b0);
        run_event(1'b1, 1'b0, 4);
        do_reset(5'd0, 1'b0);
        do_reset(5'd11, 1'b0);
        run_event(1'b0, 1'b1, 4);

        for (int d = 1; d <= 3; d++) mid_reset(d, 5'($urandom_range(0, 31)));

        // Randomized event sequences, with occasional re-reset.
        for (int i = 0; i < 150; i++) begin
            int kind;
            if ($urandom_range(0, 19) == 0)
                do_reset(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            kind = $urandom_range(0, 2);
            run_event(kind != 1, kind != 0, $urandom_range(4, 8));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
